generador_trafico: RTL

Synthesizable, parametrised traffic and configuration sequencer for the switch datapath. It replaces the hand-scripted stimulus for FIFO-threshold and destination-routing checks. On each run it programs the MF/VC/D thresholds with an `init` pulse, then pushes a burst of pseudo-random words that honour `Main_pause`. It drains every destination FIFO and reports completion. It sits in front of the switch top level, in both the bench and the on-chip self-test wrapper.

---
 rtl/tg_pkg.sv | 24 ++
 rtl/lfsr16_gen.sv | 35 +++
 rtl/generador_trafico.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/tg_pkg.sv
// Shared types and constants for the traffic/config sequencer.
// FSM encoding, LFSR polynomial, drain quiet length, clog2 helper.
package tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_FILL  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } tg_state_e;

  localparam logic [15:0] TG_LFSR_POLY   = 16'hB400;
  localparam int          TG_DRAIN_QUIET = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/lfsr16_gen.sv
// 16-bit right-shifting Galois LFSR with seed load and advance enable.
// A zero seed is replaced by 1 so the register never locks up.
module lfsr16_gen
  import tg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] value
);

  logic [15:0] value_q, value_d;
  logic [15:0] seed_nz;

  assign seed_nz = (seed == 16'h0) ? 16'h0001 : seed;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = seed_nz;
    end else if (advance) begin
      value_d = (value_q >> 1) ^ (value_q[0] ? TG_LFSR_POLY : 16'h0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) value_q <= seed_nz;
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/generador_trafico.sv
// Traffic/config sequencer: init pulse, LFSR burst, FIFO drain, done.
// TG_ROUND_ROBIN_DEST_EN selects round-robin destinations over LFSR ones.
module generador_trafico
  import tg_pkg::*;
#(
  parameter int          BITNUMBER = 8,
  parameter int          NUM_DEST  = 2,
  parameter int          DEST_LSB  = 4,
  parameter int          BURST_LEN = 16,
  parameter int          IDLE_GAP  = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          UMBRAL_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [UMBRAL_W-1:0]  cfg_MF,
  input  logic [UMBRAL_W-1:0]  cfg_VC,
  input  logic [UMBRAL_W-1:0]  cfg_D,
  input  logic                 Main_pause,
  input  logic [NUM_DEST-1:0]  D_can_pop,
  output logic                 init,
  output logic [UMBRAL_W-1:0]  Umbral_MF_prob,
  output logic [UMBRAL_W-1:0]  Umbral_VC_prob,
  output logic [UMBRAL_W-1:0]  Umbral_D_prob,
  output logic                 push,
  output logic [BITNUMBER-1:0] data_in,
  output logic [NUM_DEST-1:0]  pop_D,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          sent_count
);

  localparam int          DW         = clog2(NUM_DEST);
  localparam logic [15:0] BURST_MAX  = 16'(BURST_LEN);
  localparam logic [15:0] GAP_LAST   =
    16'((IDLE_GAP == 0) ? 0 : IDLE_GAP - 1);
  localparam logic [1:0]  QUIET_LAST = 2'(TG_DRAIN_QUIET - 1);

  tg_state_e           state_q, state_d;
  logic [UMBRAL_W-1:0] mf_q, mf_d;
  logic [UMBRAL_W-1:0] vc_q, vc_d;
  logic [UMBRAL_W-1:0] d_q, d_d;
  logic [15:0]         sent_q, sent_d;
  logic [15:0]         gap_q, gap_d;
  logic [1:0]          quiet_q, quiet_d;
  logic [NUM_DEST-1:0] pop_q, pop_d;
  logic [15:0]         lfsr_value;
  logic [15:0]         word;
  logic [DW-1:0]       dest;
  logic                accept;
  logic                push_int;

  assign accept   = (state_q == ST_IDLE) && start;
  assign push_int = (state_q == ST_FILL) && !Main_pause
                    && (sent_q < BURST_MAX);

  lfsr16_gen u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .seed    (LFSR_SEED),
    .advance (push_int),
    .value   (lfsr_value)
  );

`ifdef TG_ROUND_ROBIN_DEST_EN
  logic [DW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = '0;
    end else if (push_int) begin
      ptr_d = (ptr_q == DW'(NUM_DEST - 1)) ? '0 : ptr_q + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign dest = ptr_q;
`else
  assign dest = DW'(int'(lfsr_value[15 -: DW]) % NUM_DEST);
`endif

  always_comb begin
    word = lfsr_value;
    word[DEST_LSB +: DW] = dest;
  end

  assign data_in = BITNUMBER'(word);

  always_comb begin
    state_d = state_q;
    mf_d    = mf_q;
    vc_d    = vc_q;
    d_d     = d_q;
    sent_d  = sent_q;
    gap_d   = gap_q;
    quiet_d = quiet_q;
    pop_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_INIT;
          mf_d    = cfg_MF;
          vc_d    = cfg_VC;
          d_d     = cfg_D;
          sent_d  = '0;
        end
      end
      ST_INIT: state_d = ST_FILL;
      ST_FILL: begin
        if (push_int) begin
          sent_d = sent_q + 16'd1;
          if (sent_q + 16'd1 == BURST_MAX) begin
            state_d = ST_DRAIN;
            quiet_d = '0;
          end
        end
      end
      ST_DRAIN: begin
        pop_d = D_can_pop;
        if (|D_can_pop) begin
          quiet_d = '0;
        end else if (quiet_q == QUIET_LAST) begin
          quiet_d = '0;
          gap_d   = '0;
          state_d = (IDLE_GAP == 0) ? ST_DONE : ST_GAP;
        end else begin
          quiet_d = quiet_q + 2'd1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_DONE;
        else                   gap_d   = gap_q + 16'd1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mf_q    <= '0;
      vc_q    <= '0;
      d_q     <= '0;
      sent_q  <= '0;
      gap_q   <= '0;
      quiet_q <= '0;
      pop_q   <= '0;
    end else begin
      state_q <= state_d;
      mf_q    <= mf_d;
      vc_q    <= vc_d;
      d_q     <= d_d;
      sent_q  <= sent_d;
      gap_q   <= gap_d;
      quiet_q <= quiet_d;
      pop_q   <= pop_d;
    end
  end

  assign init           = (state_q == ST_INIT);
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign push           = push_int;
  assign pop_D          = pop_q;
  assign sent_count     = sent_q;
  assign Umbral_MF_prob = mf_q;
  assign Umbral_VC_prob = vc_q;
  assign Umbral_D_prob  = d_q;

endmodule
